// File: rtl/cond_issue_scheduler_pkg.sv
// Shared types for the conditional issue scheduler: flag-count source, the
// single-flag conditional descriptor, FSM states and the condition evaluator.
package EV_types;
  localparam int flagCount = 4;
endpackage

package SimpleConditional;
  localparam int SKIP_COUNT_W = 16;
  localparam int FLAG_IDX_W   = 3;
  localparam int FLAG_EXT_W   = 2 ** FLAG_IDX_W;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } sched_state_e;

  typedef logic [3:0] thread_id_t;

  typedef struct packed {
    logic [FLAG_IDX_W-1:0] flag;
    logic                  condition;
    logic                  negate;
  } singleFlagConditional_a;

  // Unconditional ops resolve to !negate; flag indices past flag_count read as 0.
  function automatic logic cond_result(input singleFlagConditional_a c,
                                       input logic [FLAG_EXT_W-1:0] flags,
                                       input int flag_count);
    logic sel;
    logic res;
    sel = 1'b0;
    if (!c.condition) begin
      res = !c.negate;
    end else begin
      if (int'(c.flag) < flag_count) sel = flags[c.flag];
      else                           sel = 1'b0;
      res = sel ^ c.negate;
    end
    return res;
  endfunction
endpackage

// File: rtl/cond_issue_scheduler_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr wins,
// returned as a one-hot grant.
module rr_pick #(
  parameter  int THREADS = 4,
  localparam int TW      = $clog2(THREADS)
) (
  input  logic [THREADS-1:0] req,
  input  logic [TW-1:0]      ptr,
  output logic [THREADS-1:0] grant
);
  logic          found_s;
  logic [TW-1:0] idx_s;

  // Scan from ptr upward with wrap; only the first hit is granted.
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int i = 0; i < THREADS; i++) begin
      idx_s        = TW'((int'(ptr) + i) % THREADS);
      grant[idx_s] = req[idx_s] && !found_s;
      found_s      = found_s || req[idx_s];
    end
  end
endmodule

// File: rtl/cond_issue_scheduler.sv
// Round-robin conditional issue scheduler: squashes ops whose flag condition
// is false. Optional saturating skip counter behind COND_SCHED_SKIP_COUNT_EN.
module cond_issue_scheduler
  import SimpleConditional::*;
#(
  parameter  int THREADS    = 4,
  parameter  int FLAG_COUNT = EV_types::flagCount,
  localparam int TW         = $clog2(THREADS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [THREADS-1:0]     req_valid,
  input  singleFlagConditional_a req_cond [THREADS],
  output logic [THREADS-1:0]     req_ready,
  output logic                   issue_valid,
  output logic [TW-1:0]          issue_thread,
  input  logic                   issue_ready,
  input  logic                   flag_wr_en,
  input  logic [TW-1:0]          flag_wr_thread,
  input  logic [FLAG_COUNT-1:0]  flag_wr_data,
  output logic                   skip_valid,
  output logic [TW-1:0]          skip_thread
`ifdef COND_SCHED_SKIP_COUNT_EN
  ,
  output logic [SKIP_COUNT_W-1:0] skip_count
`endif
);
  sched_state_e           state_r, state_nxt_s;
  logic [TW-1:0]          rr_ptr_r;
  logic [FLAG_EXT_W-1:0]  flags_r [THREADS];
  logic [THREADS-1:0]     grant_s;
  logic [TW-1:0]          winner_s;
  thread_id_t             win_id_s;
  singleFlagConditional_a win_cond_s;
  logic [FLAG_EXT_W-1:0]  win_flags_s;
  logic                   result_s;
  logic                   accept_s;
  logic                   issue_now_s;
  logic                   skip_now_s;
  logic                   issue_valid_r;
  logic [TW-1:0]          issue_thread_r;
  logic                   skip_valid_r;
  logic [TW-1:0]          skip_thread_r;

  rr_pick #(.THREADS(THREADS)) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .grant (grant_s)
  );

  // Encode the winner and evaluate its condition, bypassing a same-cycle flag write.
  always_comb begin
    winner_s = '0;
    for (int i = 0; i < THREADS; i++) begin
      if (grant_s[i]) winner_s = TW'(i);
      else            winner_s = winner_s;
    end
    win_id_s   = thread_id_t'(winner_s);
    win_cond_s = req_cond[winner_s];
    if (flag_wr_en && (flag_wr_thread == winner_s)) win_flags_s = FLAG_EXT_W'(flag_wr_data);
    else                                             win_flags_s = flags_r[winner_s];
    result_s = cond_result(win_cond_s, win_flags_s, FLAG_COUNT);
  end

  // Next-state and acceptance decode.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    issue_now_s = 1'b0;
    skip_now_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (|req_valid) begin
          accept_s = 1'b1;
          if (result_s) begin
            issue_now_s = 1'b1;
            state_nxt_s = ISSUE;
          end else begin
            skip_now_s  = 1'b1;
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (issue_ready) state_nxt_s = IDLE;
        else             state_nxt_s = ISSUE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  assign req_ready = grant_s & {THREADS{accept_s & ~reset}};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Pointer, flag storage and registered downstream outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r       <= '0;
      issue_valid_r  <= 1'b0;
      issue_thread_r <= '0;
      skip_valid_r   <= 1'b0;
      skip_thread_r  <= '0;
      for (int t = 0; t < THREADS; t++) flags_r[t] <= '0;
    end else begin
      if (accept_s) begin
        rr_ptr_r <= (win_id_s == thread_id_t'(THREADS - 1)) ? '0 : TW'(win_id_s + 4'd1);
      end
      issue_valid_r <= (state_nxt_s == ISSUE);
      if (issue_now_s) issue_thread_r <= winner_s;
      skip_valid_r <= skip_now_s;
      if (skip_now_s) skip_thread_r <= winner_s;
      if (flag_wr_en) flags_r[flag_wr_thread] <= FLAG_EXT_W'(flag_wr_data);
    end
  end

  assign issue_valid  = issue_valid_r;
  assign issue_thread = issue_thread_r;
  assign skip_valid   = skip_valid_r;
  assign skip_thread  = skip_thread_r;

`ifdef COND_SCHED_SKIP_COUNT_EN
  logic [SKIP_COUNT_W-1:0] skip_count_r;

  // Saturating count of squashed ops.
  always_ff @(posedge clk) begin
    if (reset) begin
      skip_count_r <= '0;
    end else if (skip_now_s && (skip_count_r != {SKIP_COUNT_W{1'b1}})) begin
      skip_count_r <= skip_count_r + 16'd1;
    end else begin
      skip_count_r <= skip_count_r;
    end
  end

  assign skip_count = skip_count_r;
`endif
endmodule

// File: tb/tb_cond_issue_scheduler.sv
// Self-checking bench for cond_issue_scheduler: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_cond_issue_scheduler;
  import SimpleConditional::*;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [3:0]             req_valid;
  singleFlagConditional_a req_cond [4];
  logic [3:0]             req_ready;
  logic                   issue_valid;
  logic [1:0]             issue_thread;
  logic                   issue_ready;
  logic                   flag_wr_en;
  logic [1:0]             flag_wr_thread;
  logic [3:0]             flag_wr_data;
  logic                   skip_valid;
  logic [1:0]             skip_thread;
`ifdef COND_SCHED_SKIP_COUNT_EN
  logic [15:0]            skip_count;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Behavioural model state
  int         m_ptr;
  bit         m_busy;
  logic [3:0] m_flags [4];
  bit         m_issue_valid;
  int         m_issue_thread;
  bit         m_skip_valid;
  int         m_skip_thread;
  int         m_skip_count;

  cond_issue_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_cond       (req_cond),
    .req_ready      (req_ready),
    .issue_valid    (issue_valid),
    .issue_thread   (issue_thread),
    .issue_ready    (issue_ready),
    .flag_wr_en     (flag_wr_en),
    .flag_wr_thread (flag_wr_thread),
    .flag_wr_data   (flag_wr_data),
    .skip_valid     (skip_valid),
    .skip_thread    (skip_thread)
`ifdef COND_SCHED_SKIP_COUNT_EN
    ,
    .skip_count     (skip_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid      = 4'b0000;
    issue_ready    = 1'b1;
    flag_wr_en     = 1'b0;
    flag_wr_thread = 2'd0;
    flag_wr_data   = 4'b0000;
    for (int i = 0; i < 4; i++) req_cond[i] = '{flag: 3'd0, condition: 1'b0, negate: 1'b0};
  endtask

  function automatic int model_winner();
    if (m_busy || reset) return -1;
    for (int i = 0; i < 4; i++) begin
      if (req_valid[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
    end
    return -1;
  endfunction

  function automatic bit model_eval(int t);
    logic [3:0] fv;
    int         idx;
    fv  = (flag_wr_en && int'(flag_wr_thread) == t) ? flag_wr_data : m_flags[t];
    idx = int'(req_cond[t].flag);
    if (!req_cond[t].condition) return !req_cond[t].negate;
    if (idx >= 4) return req_cond[t].negate;
    return fv[idx] ^ req_cond[t].negate;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_clock();
    int w;
    bit e;
    w = model_winner();
    e = (w >= 0) ? model_eval(w) : 1'b0;
    m_skip_valid = 1'b0;
    if (reset) begin
      m_busy = 0; m_ptr = 0; m_issue_thread = 0; m_skip_thread = 0; m_skip_count = 0;
      for (int i = 0; i < 4; i++) m_flags[i] = 4'b0000;
    end else begin
      if (m_busy) begin
        if (issue_ready) m_busy = 0;
      end else if (w >= 0) begin
        m_ptr = (w + 1) % 4;
        if (e) begin
          m_busy = 1; m_issue_thread = w;
        end else begin
          m_skip_valid = 1'b1; m_skip_thread = w;
          if (m_skip_count < 65535) m_skip_count++;
        end
      end
      if (flag_wr_en) m_flags[flag_wr_thread] = flag_wr_data;
    end
    m_issue_valid = m_busy;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    model_clock();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    req_valid = 4'b1111;
    #1;
    total_cnt++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready got=%b exp=0000", req_ready); else pass_cnt++;
    model_clock();
    tick();
    reset = 1'b0;
    req_valid = 4'b0000;
    #1;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL reset_issue_valid got=%b exp=0", issue_valid); else pass_cnt++;
    total_cnt++; if (issue_thread !== 2'd0) $display("FAIL reset_issue_thread got=%0d exp=0", issue_thread); else pass_cnt++;
    total_cnt++; if (skip_valid !== 1'b0) $display("FAIL reset_skip_valid got=%b exp=0", skip_valid); else pass_cnt++;
`ifdef COND_SCHED_SKIP_COUNT_EN
    total_cnt++; if (skip_count !== 16'd0) $display("FAIL reset_skip_count got=%0d exp=0", skip_count); else pass_cnt++;
`endif
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      exp = 4'b0001 << (k % 4);
      total_cnt++; if (req_ready !== exp) $display("FAIL rr_ready k=%0d got=%b exp=%b", k, req_ready, exp); else pass_cnt++;
      tick();
      total_cnt++; if (issue_valid !== 1'b1) $display("FAIL rr_issue_valid k=%0d got=%b exp=1", k, issue_valid); else pass_cnt++;
      total_cnt++; if (issue_thread !== 2'(k % 4)) $display("FAIL rr_issue_thread k=%0d got=%0d exp=%0d", k, issue_thread, k % 4); else pass_cnt++;
      total_cnt++; if (req_ready !== 4'b0000) $display("FAIL rr_ready_in_issue k=%0d got=%b exp=0000", k, req_ready); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_skip_and_negate();
    for (int neg = 0; neg < 2; neg++) begin
      do_reset();
      req_valid   = 4'b0010;
      req_cond[1] = '{flag: 3'd0, condition: 1'b1, negate: 1'(neg)};
      #1;
      total_cnt++; if (req_ready !== 4'b0010) $display("FAIL cond_ready neg=%0d got=%b exp=0010", neg, req_ready); else pass_cnt++;
      tick();
      req_valid = 4'b0000;
      total_cnt++; if (skip_valid !== 1'(1 - neg)) $display("FAIL cond_skip_valid neg=%0d got=%b exp=%0d", neg, skip_valid, 1 - neg); else pass_cnt++;
      total_cnt++; if (issue_valid !== 1'(neg)) $display("FAIL cond_issue_valid neg=%0d got=%b exp=%0d", neg, issue_valid, neg); else pass_cnt++;
      if (neg == 0) begin
        total_cnt++; if (skip_thread !== 2'd1) $display("FAIL skip_thread got=%0d exp=1", skip_thread); else pass_cnt++;
      end else begin
        total_cnt++; if (issue_thread !== 2'd1) $display("FAIL negate_issue_thread got=%0d exp=1", issue_thread); else pass_cnt++;
      end
      tick();
      total_cnt++; if (skip_valid !== 1'b0) $display("FAIL skip_pulse_width neg=%0d got=%b exp=0", neg, skip_valid); else pass_cnt++;
      total_cnt++; if (issue_valid !== 1'b0) $display("FAIL cond_issue_after neg=%0d got=%b exp=0", neg, issue_valid); else pass_cnt++;
    end
  endtask

  task automatic test_bypass_and_oob();
    do_reset();
    req_valid      = 4'b0100;
    req_cond[2]    = '{flag: 3'd0, condition: 1'b1, negate: 1'b0};
    flag_wr_en     = 1'b1;
    flag_wr_thread = 2'd2;
    flag_wr_data   = 4'b0001;
    #1;
    total_cnt++; if (req_ready !== 4'b0100) $display("FAIL bypass_ready got=%b exp=0100", req_ready); else pass_cnt++;
    tick();
    idle_inputs();
    total_cnt++; if (issue_valid !== 1'b1) $display("FAIL bypass_issue_valid got=%b exp=1", issue_valid); else pass_cnt++;
    total_cnt++; if (issue_thread !== 2'd2) $display("FAIL bypass_issue_thread got=%0d exp=2", issue_thread); else pass_cnt++;
    flag_wr_en = 1'b1; flag_wr_thread = 2'd0; flag_wr_data = 4'b1111;
    tick();
    flag_wr_en  = 1'b0;
    req_valid   = 4'b0001;
    req_cond[0] = '{flag: 3'd5, condition: 1'b1, negate: 1'b0};
    tick();
    req_valid = 4'b0000;
    total_cnt++; if (skip_valid !== 1'b1) $display("FAIL oob_flag_skip got=%b exp=1", skip_valid); else pass_cnt++;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL oob_flag_issue got=%b exp=0", issue_valid); else pass_cnt++;
  endtask

  task automatic test_stall();
    do_reset();
    req_valid   = 4'b1111;
    issue_ready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      total_cnt++; if (issue_valid !== 1'b1) $display("FAIL stall_valid k=%0d got=%b exp=1", k, issue_valid); else pass_cnt++;
      total_cnt++; if (issue_thread !== 2'd0) $display("FAIL stall_thread k=%0d got=%0d exp=0", k, issue_thread); else pass_cnt++;
      total_cnt++; if (req_ready !== 4'b0000) $display("FAIL stall_ready k=%0d got=%b exp=0000", k, req_ready); else pass_cnt++;
      tick();
    end
    issue_ready = 1'b1;
    tick();
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL stall_release got=%b exp=0", issue_valid); else pass_cnt++;
    total_cnt++; if (req_ready !== 4'b0010) $display("FAIL stall_next_ptr got=%b exp=0010", req_ready); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) req_cond[i] = '{flag: 3'd0, condition: 1'b0, negate: 1'b1};
    #1;
    for (int k = 0; k < 5; k++) begin
      exp = 4'b0001 << (k % 4);
      total_cnt++; if (req_ready !== exp) $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, req_ready, exp); else pass_cnt++;
      tick();
      total_cnt++; if (skip_valid !== 1'b1) $display("FAIL b2b_skip_valid k=%0d got=%b exp=1", k, skip_valid); else pass_cnt++;
      total_cnt++; if (skip_thread !== 2'(k % 4)) $display("FAIL b2b_skip_thread k=%0d got=%0d exp=%0d", k, skip_thread, k % 4); else pass_cnt++;
      total_cnt++; if (issue_valid !== 1'b0) $display("FAIL b2b_issue_valid k=%0d got=%b exp=0", k, issue_valid); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_issue();
    do_reset();
    req_valid = 4'b0111;
    for (int i = 0; i < 3; i++) req_cond[i] = '{flag: 3'd0, condition: 1'b0, negate: 1'b1};
    tick(); tick(); tick();
    req_valid   = 4'b1000;
    issue_ready = 1'b0;
    tick();
    req_valid = 4'b0000;
    total_cnt++; if (issue_valid !== 1'b1) $display("FAIL mid_issue_valid got=%b exp=1", issue_valid); else pass_cnt++;
`ifdef COND_SCHED_SKIP_COUNT_EN
    total_cnt++; if (skip_count !== 16'd3) $display("FAIL skip_count got=%0d exp=3", skip_count); else pass_cnt++;
`endif
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    issue_ready = 1'b1;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL mid_reset_valid got=%b exp=0", issue_valid); else pass_cnt++;
`ifdef COND_SCHED_SKIP_COUNT_EN
    total_cnt++; if (skip_count !== 16'd0) $display("FAIL mid_reset_count got=%0d exp=0", skip_count); else pass_cnt++;
`endif
    tick();
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL mid_reset_dropped got=%b exp=0", issue_valid); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [3:0] exp_ready;
    int         w;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      total_cnt++; if (issue_valid !== 1'(m_issue_valid)) $display("FAIL rnd_issue_valid c=%0d got=%b exp=%0d", c, issue_valid, m_issue_valid); else pass_cnt++;
      total_cnt++; if (issue_thread !== 2'(m_issue_thread)) $display("FAIL rnd_issue_thread c=%0d got=%0d exp=%0d", c, issue_thread, m_issue_thread); else pass_cnt++;
      total_cnt++; if (skip_valid !== 1'(m_skip_valid)) $display("FAIL rnd_skip_valid c=%0d got=%b exp=%0d", c, skip_valid, m_skip_valid); else pass_cnt++;
      if (m_skip_valid) begin
        total_cnt++; if (skip_thread !== 2'(m_skip_thread)) $display("FAIL rnd_skip_thread c=%0d got=%0d exp=%0d", c, skip_thread, m_skip_thread); else pass_cnt++;
      end
`ifdef COND_SCHED_SKIP_COUNT_EN
      total_cnt++; if (skip_count !== 16'(m_skip_count)) $display("FAIL rnd_skip_count c=%0d got=%0d exp=%0d", c, skip_count, m_skip_count); else pass_cnt++;
`endif
      reset          = ($urandom_range(0, 63) == 0);
      req_valid      = 4'($urandom);
      issue_ready    = 1'($urandom);
      flag_wr_en     = ($urandom_range(0, 3) == 0);
      flag_wr_thread = 2'($urandom);
      flag_wr_data   = 4'($urandom);
      for (int i = 0; i < 4; i++)
        req_cond[i] = '{flag: 3'($urandom_range(0, 7)), condition: 1'($urandom), negate: 1'($urandom)};
      #1;
      w = model_winner();
      exp_ready = (w >= 0) ? (4'b0001 << w) : 4'b0000;
      total_cnt++; if (req_ready !== exp_ready) $display("FAIL rnd_req_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready); else pass_cnt++;
      model_clock();
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_round_robin();
    test_skip_and_negate();
    test_bypass_and_oob();
    test_stall();
    test_back_to_back();
    test_reset_mid_issue();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/cond_issue_scheduler.md
COND_ISSUE_SCHEDULER -- requirements
Module: cond_issue_scheduler

Interface
REQ-001 SHALL have parameter THREADS, default 4: number of requesting threads (2..16).
REQ-002 SHALL have parameter FLAG_COUNT, default EV_types::flagCount: flags per thread.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, THREADS: thread t requests issue of one conditional op.
REQ-006 SHALL have port req_cond, input, THREADS x singleFlagConditional_a: per-thread {flag, condition, negate}.
REQ-007 SHALL have port req_ready, output, THREADS: one-hot acceptance strobe for the accepted thread.
REQ-008 SHALL have port issue_valid, output, 1: an op is presented downstream.
REQ-009 SHALL have port issue_thread, output, $clog2(THREADS): thread id of the presented op.
REQ-010 SHALL have port issue_ready, input, 1: downstream accepts when high with issue_valid.
REQ-011 SHALL have port flag_wr_en, input, 1: writes the flag vector of one thread.
REQ-012 SHALL have port flag_wr_thread, input, $clog2(THREADS): target thread of the write.
REQ-013 SHALL have port flag_wr_data, input, FLAG_COUNT: new flag vector.
REQ-014 SHALL have port skip_valid, output, 1: one-cycle pulse, accepted op was squashed (condition false).

Function
REQ-015 SHALL hold one FLAG_COUNT-bit flag register per thread, written on flag_wr_en.
REQ-016 SHALL run an FSM with states IDLE, ISSUE.
- IDLE: if any req_valid, pick the winner round-robin, starting from the thread after the last winner.
- ISSUE: hold issue_valid/issue_thread until issue_ready, then return to IDLE.
REQ-017 SHALL evaluate the winner's condition in the IDLE cycle:
- condition=0: result = !negate.
- condition=1: result = flags[flag] XOR negate.
REQ-018 SHALL, in that same cycle, pulse req_ready[winner] for one cycle.
REQ-019 SHALL, if the result is true, enter ISSUE with issue_valid high on the next cycle (1-cycle latency).
REQ-020 SHALL, if the result is false, stay in IDLE, pulse skip_valid and skip_thread on the next cycle, and never assert issue_valid for that op.
REQ-021 SHALL advance the round-robin pointer on every acceptance, issued or skipped.
REQ-022 SHALL not accept a new request while in ISSUE; req_ready SHALL be all zero there.
REQ-023 SHALL, when flag_wr_en targets the winner in the evaluation cycle, evaluate using flag_wr_data (write bypass).
REQ-024 SHALL treat a flag index >= FLAG_COUNT as reading 0.
REQ-025 SHALL wrap the round-robin pointer from THREADS-1 to 0.
REQ-026 SHALL permit back-to-back skips on consecutive cycles.
REQ-027 SHALL allow issue_ready to be high in the same cycle issue_valid rises; the FSM SHALL leave ISSUE on that edge.

Reset
REQ-028 SHALL, on reset:
- FSM = IDLE, round-robin pointer = 0 (thread 0 has highest priority first).
- all flag registers = 0.
- issue_valid, req_ready, skip_valid = 0; issue_thread = 0.
REQ-029 SHALL, on reset asserted during ISSUE, drop the pending op without completing its handshake.

Configuration
REQ-030 SHALL support macro COND_SCHED_SKIP_COUNT_EN.
- Defined: adds output skip_count, 16 bits, incremented on each skip, saturating at 0xFFFF, cleared by reset.
- Undefined: the port and counter are absent.

Structure
REQ-031 SHALL place the following in package SimpleConditional: the skip_count width constant, the FSM state enum, and the thread-id typedef.
REQ-032 SHALL implement the round-robin pick as sub-module rr_pick (THREADS-bit request, pointer in, one-hot grant out, purely combinational).
REQ-033 SHALL reuse SimpleConditional::singleFlagConditional_a.

Verification
REQ-034 SHALL cover these directed scenarios:
- Reset, then req_valid=4'b1111, all conditions always-true, issue_ready=1 -> issue_thread sequence 0,1,2,3,0; issue_valid 1 cycle after each req_ready.
- flags[t1]=0, t1 cond {flag=0, condition=1, negate=0} -> req_ready[1] pulse, skip_valid=1, skip_thread=1, no issue_valid.
- Same as above with negate=1 -> issue_valid, issue_thread=1.
- flag_wr_en to t2 writing 1 in the same cycle t2 wins, cond on flag 0 -> issued (bypass).
- issue_ready held low 5 cycles -> issue_valid held, req_ready=0 throughout, issue_thread stable.
- With COND_SCHED_SKIP_COUNT_EN, 3 skips -> skip_count=3; reset mid-ISSUE -> issue_valid=0 and skip_count=0 next cycle.
